riscv_timer_intc: RTL and testbench

Memory-mapped machine-timer and external-interrupt front end. It sits upstream of riscv_pipelined_top and drives that block's t_intr and e_intr inputs. The core's MEM stage accesses it through a word-wide load/store port decoded from the data address space. It holds a 64-bit mtime counter, a 64-bit mtimecmp compare register, a control register and an external-interrupt pending latch.

---
 rtl/riscv_timer_pkg.sv | 46 ++++
 rtl/riscv_timer_intc_if.sv | 31 +++
 rtl/riscv_irq_sync.sv | 36 +++
 rtl/riscv_timer_intc.sv | 183 ++++++++++++++++++
 tb/tb_riscv_timer_intc.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_timer_pkg.sv
// Shared definitions for the machine-timer / external-interrupt front end:
// register offsets (addr_i[4:2]), CTRL bit layout, the CTRL struct and
// reset constants. CTRL.PSC only carries state when the
// RISCV_TIMER_PRESCALE_EN macro is defined; it reads as zero otherwise.
package riscv_timer_pkg;

    // Prescaler width; ctrl_t depends on it, so it lives here.
    localparam int PSW = 8;

    // Word offsets decoded from addr_i[4:2]. Offsets 6 and 7 are reserved.
    localparam logic [2:0] MTIME_LO_OFF    = 3'd0;
    localparam logic [2:0] MTIME_HI_OFF    = 3'd1;
    localparam logic [2:0] MTIMECMP_LO_OFF = 3'd2;
    localparam logic [2:0] MTIMECMP_HI_OFF = 3'd3;
    localparam logic [2:0] CTRL_OFF        = 3'd4;
    localparam logic [2:0] EXT_PEND_OFF    = 3'd5;

    // Bit positions inside the CTRL word.
    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_TIE_BIT = 1;
    localparam int CTRL_EIE_BIT = 2;
    localparam int CTRL_PSC_LSB = 8;

    // mtimecmp resets to all ones so no timer interrupt fires before software
    // programs a deadline.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct packed {
        logic [PSW-1:0] psc;
        logic           eie;
        logic           tie;
        logic           en;
    } ctrl_t;

    // Pack the CTRL struct into its bus-visible 32-bit layout.
    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        logic [31:0] word;
        word                         = '0;
        word[CTRL_EN_BIT]            = c.en;
        word[CTRL_TIE_BIT]           = c.tie;
        word[CTRL_EIE_BIT]           = c.eie;
        word[CTRL_PSC_LSB +: PSW]    = c.psc;
        return word;
    endfunction

endpackage

// File: rtl/riscv_timer_intc_if.sv
// Word-wide load/store port between the core's MEM stage and the timer block.
// Access protocol: there is no valid/ready pair. sel_i qualifies an access for
// exactly one cycle; a write (sel_i & we_i) is committed at the next rising
// clock edge and is never back-pressured; rdata_o is purely combinational from
// addr_i, so a load returns data in the same cycle it is presented.
interface riscv_timer_intc_if #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
);
    logic             sel_i;
    logic             we_i;
    logic [ADDRW-1:0] addr_i;
    logic [DW-1:0]    wdata_i;
    logic [DW-1:0]    rdata_o;

    modport master (
        output sel_i,
        output we_i,
        output addr_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  sel_i,
        input  we_i,
        input  addr_i,
        input  wdata_i,
        output rdata_o
    );
endinterface

// File: rtl/riscv_irq_sync.sv
// Two-flop synchronizer for an asynchronous interrupt request followed by a
// rising-edge detector. rise_o is high for one clock when the synchronized
// level goes 0 -> 1.
module riscv_irq_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Next-state: shift the request through the sync chain and history flop.
    always_comb begin
        sync1_d = async_i;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // Synchronizer and edge-history registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/riscv_timer_intc.sv
// Machine timer and external-interrupt front end feeding t_intr / e_intr of the
// pipelined core. Holds a 64-bit mtime, a 64-bit mtimecmp, CTRL and an
// external-interrupt pending latch, all reachable through a word-wide
// load/store port with combinational reads.
// Build option: define RISCV_TIMER_PRESCALE_EN to include the tick prescaler
// and CTRL.PSC; without it mtime advances every cycle while EN=1.
module riscv_timer_intc #(
    parameter int DW    = 32,
    parameter int ADDRW = 12
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    riscv_timer_intc_if.slave        bus,
    input  logic                     ext_irq_i,
    output logic                     t_intr,
    output logic                     e_intr
);
    import riscv_timer_pkg::*;

    logic [ADDRW-1:0] addr;
    logic [DW-1:0]    wdata;
    logic [DW-1:0]    rdata;
    logic [2:0]       reg_idx;
    logic             wr_en;

    assign addr    = bus.addr_i;
    assign wdata   = bus.wdata_i;
    assign wr_en   = bus.sel_i & bus.we_i;
    assign reg_idx = addr[4:2];

    // Byte-lane and upper offset bits carry no meaning for this block.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[ADDRW-1:5], addr[1:0]};

    logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_pend;

    assign wr_mtime_lo = wr_en && (reg_idx == MTIME_LO_OFF);
    assign wr_mtime_hi = wr_en && (reg_idx == MTIME_HI_OFF);
    assign wr_cmp_lo   = wr_en && (reg_idx == MTIMECMP_LO_OFF);
    assign wr_cmp_hi   = wr_en && (reg_idx == MTIMECMP_HI_OFF);
    assign wr_ctrl     = wr_en && (reg_idx == CTRL_OFF);
    assign wr_pend     = wr_en && (reg_idx == EXT_PEND_OFF);

    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    ctrl_t       ctrl_q,     ctrl_d;
    logic        pending_q,  pending_d;
    logic        t_intr_q,   t_intr_d;
    logic        e_intr_q,   e_intr_d;
    logic        tick;
    logic        ext_rise;

    riscv_irq_sync u_irq_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (ext_irq_i),
        .rise_o  (ext_rise)
    );

`ifdef RISCV_TIMER_PRESCALE_EN
    logic [PSW-1:0] psc_cnt_q, psc_cnt_d;

    // Prescaler: count 0..PSC and emit one tick when the count hits PSC.
    always_comb begin
        psc_cnt_d = psc_cnt_q;
        tick      = 1'b0;
        if (ctrl_q.en) begin
            if (psc_cnt_q == ctrl_q.psc) begin
                tick      = 1'b1;
                psc_cnt_d = '0;
            end else begin
                psc_cnt_d = psc_cnt_q + 1'b1;
            end
        end else begin
            psc_cnt_d = '0;
        end
        // Reprogramming CTRL restarts the division phase.
        if (wr_ctrl) begin
            psc_cnt_d = '0;
        end
    end

    // Prescale count register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            psc_cnt_q <= '0;
        end else begin
            psc_cnt_q <= psc_cnt_d;
        end
    end
`else
    // Without the prescaler mtime advances on every enabled cycle.
    assign tick = ctrl_q.en;
`endif

    // Next-state for mtime: a software write to either half pre-empts the tick.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime_lo) begin
            mtime_d = {mtime_q[63:32], wdata[31:0]};
        end else if (wr_mtime_hi) begin
            mtime_d = {wdata[31:0], mtime_q[31:0]};
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Next-state for mtimecmp and CTRL.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        ctrl_d     = ctrl_q;
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = wdata[31:0];
        end
        if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = wdata[31:0];
        end
        if (wr_ctrl) begin
            ctrl_d.en  = wdata[CTRL_EN_BIT];
            ctrl_d.tie = wdata[CTRL_TIE_BIT];
            ctrl_d.eie = wdata[CTRL_EIE_BIT];
`ifdef RISCV_TIMER_PRESCALE_EN
            ctrl_d.psc = wdata[CTRL_PSC_LSB +: PSW];
`else
            ctrl_d.psc = '0;
`endif
        end
    end

    // Pending latch and interrupt outputs. A new edge beats a same-cycle
    // write-1-to-clear so a request arriving during the clear is not lost.
    // e_intr follows the next pending value so it tracks the latch without
    // an extra cycle of delay.
    always_comb begin
        pending_d = pending_q;
        if (wr_pend && wdata[0]) begin
            pending_d = 1'b0;
        end
        if (ext_rise) begin
            pending_d = 1'b1;
        end
        t_intr_d = ctrl_q.tie & (mtime_q >= mtimecmp_q);
        e_intr_d = ctrl_q.eie & pending_d;
    end

    // Architectural state registers; reset overrides any same-cycle write.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            t_intr_q   <= 1'b0;
            e_intr_q   <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            t_intr_q   <= t_intr_d;
            e_intr_q   <= e_intr_d;
        end
    end

    // Combinational read mux; reserved offsets read as zero.
    always_comb begin
        rdata = '0;
        case (reg_idx)
            MTIME_LO_OFF:    rdata = mtime_q[31:0];
            MTIME_HI_OFF:    rdata = mtime_q[63:32];
            MTIMECMP_LO_OFF: rdata = mtimecmp_q[31:0];
            MTIMECMP_HI_OFF: rdata = mtimecmp_q[63:32];
            CTRL_OFF:        rdata = ctrl_to_word(ctrl_q);
            EXT_PEND_OFF:    rdata = {{(DW-1){1'b0}}, pending_q};
            default:         rdata = '0;
        endcase
    end

    assign bus.rdata_o = rdata;
    assign t_intr      = t_intr_q;
    assign e_intr      = e_intr_q;

endmodule

// File: tb/tb_riscv_timer_intc.sv
// Directed bench for riscv_timer_intc: reset values, reserved/alias decode,
// prescaled tick rate, timer compare interrupt, 64-bit wrap and write
// priority, external interrupt latch and reset in the middle of activity.
module tb_riscv_timer_intc;

    logic clk_i     = 1'b0;
    logic rst_ni    = 1'b0;
    logic ext_irq_i = 1'b0;
    logic t_intr;
    logic e_intr;

    int checks   = 0;
    int failures = 0;

    localparam logic [11:0] A_MTIME_LO = 12'h000;
    localparam logic [11:0] A_MTIME_HI = 12'h004;
    localparam logic [11:0] A_CMP_LO   = 12'h008;
    localparam logic [11:0] A_CMP_HI   = 12'h00C;
    localparam logic [11:0] A_CTRL     = 12'h010;
    localparam logic [11:0] A_PEND     = 12'h014;
    localparam logic [11:0] A_RSV6     = 12'h018;
    localparam logic [11:0] A_RSV7     = 12'h01C;

`ifdef RISCV_TIMER_PRESCALE_EN
    localparam logic [31:0] EXP_MTIME_40 = 32'd10;
    localparam logic [31:0] EXP_CTRL_301 = 32'h0000_0301;
    localparam logic [31:0] EXP_CTRL_ALL = 32'h0000_FF07;
`else
    localparam logic [31:0] EXP_MTIME_40 = 32'd40;
    localparam logic [31:0] EXP_CTRL_301 = 32'h0000_0001;
    localparam logic [31:0] EXP_CTRL_ALL = 32'h0000_0007;
`endif

    riscv_timer_intc_if #(.DW(32), .ADDRW(12)) bus_if ();

    riscv_timer_intc #(.DW(32), .ADDRW(12)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .bus       (bus_if),
        .ext_irq_i (ext_irq_i),
        .t_intr    (t_intr),
        .e_intr    (e_intr)
    );

    // Clock: period 100, rising edges at 50, 150, ...
    always #50 clk_i = ~clk_i;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        bus_if.sel_i   = 1'b1;
        bus_if.we_i    = 1'b1;
        bus_if.addr_i  = a;
        bus_if.wdata_i = d;
        @(posedge clk_i);
        #1;
        bus_if.sel_i = 1'b0;
        bus_if.we_i  = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        bus_if.sel_i  = 1'b1;
        bus_if.we_i   = 1'b0;
        bus_if.addr_i = a;
        #1;
        d = bus_if.rdata_o;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_ni = 1'b0;
        step(2);
        rst_ni = 1'b1;
        bus_read(A_CMP_LO, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_lo got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        bus_read(A_CMP_HI, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp_hi got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_mtime_lo got=%h exp=0", rd); end
        bus_read(A_MTIME_HI, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_mtime_hi got=%h exp=0", rd); end
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", rd); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_pend got=%h exp=0", rd); end
        checks++; if (t_intr !== 1'b0) begin failures++; $display("FAIL reset_t_intr got=%b exp=0", t_intr); end
        checks++; if (e_intr !== 1'b0) begin failures++; $display("FAIL reset_e_intr got=%b exp=0", e_intr); end
        step(3);
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL disabled_hold got=%h exp=0", rd); end
    endtask

    task automatic test_decode();
        logic [31:0] rd;
        bus_write(A_RSV6, 32'hFFFF_FFFF);
        bus_write(A_RSV7, 32'hFFFF_FFFF);
        bus_read(A_RSV6, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rsv6_read got=%h exp=0", rd); end
        bus_read(A_RSV7, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rsv7_read got=%h exp=0", rd); end
        // Offset 0x40B decodes as MTIMECMP_LO (bits [1:0] and above [4] ignored).
        bus_write(12'h40B, 32'h1234_5678);
        bus_read(A_CMP_LO, rd);
        checks++; if (rd !== 32'h1234_5678) begin failures++; $display("FAIL alias_cmp_lo got=%h exp=%h", rd, 32'h1234_5678); end
        bus_read(A_CMP_HI, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL alias_cmp_hi got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        bus_write(A_CTRL, 32'hFFFF_FFFF);
        bus_read(A_CTRL, rd);
        checks++; if (rd !== EXP_CTRL_ALL) begin failures++; $display("FAIL ctrl_mask got=%h exp=%h", rd, EXP_CTRL_ALL); end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_prescaler();
        logic [31:0] rd;
        bus_write(A_MTIME_LO, 32'h0);
        bus_write(A_MTIME_HI, 32'h0);
        bus_write(A_CTRL, 32'h0000_0301);
        step(40);
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== EXP_MTIME_40) begin failures++; $display("FAIL psc_mtime got=%0d exp=%0d", rd, EXP_MTIME_40); end
        bus_read(A_CTRL, rd);
        checks++; if (rd !== EXP_CTRL_301) begin failures++; $display("FAIL psc_ctrl got=%h exp=%h", rd, EXP_CTRL_301); end
        checks++; if (t_intr !== 1'b0) begin failures++; $display("FAIL psc_t_intr got=%b exp=0", t_intr); end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_timer_irq();
        logic [31:0] rd;
        bus_write(A_CMP_HI, 32'h0);
        bus_write(A_CMP_LO, 32'd20);
        bus_write(A_MTIME_LO, 32'h0);
        bus_write(A_MTIME_HI, 32'h0);
        bus_write(A_CTRL, 32'h3);
        step(19);
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'd19) begin failures++; $display("FAIL tmr_mtime19 got=%0d exp=19", rd); end
        checks++; if (t_intr !== 1'b0) begin failures++; $display("FAIL tmr_below got=%b exp=0", t_intr); end
        step(1);
        checks++; if (t_intr !== 1'b0) begin failures++; $display("FAIL tmr_equal_latency got=%b exp=0", t_intr); end
        step(1);
        checks++; if (t_intr !== 1'b1) begin failures++; $display("FAIL tmr_rise got=%b exp=1", t_intr); end
        bus_write(A_CMP_LO, 32'd1000);
        checks++; if (t_intr !== 1'b1) begin failures++; $display("FAIL tmr_clear_latency got=%b exp=1", t_intr); end
        step(1);
        checks++; if (t_intr !== 1'b0) begin failures++; $display("FAIL tmr_clear_cmp got=%b exp=0", t_intr); end
        bus_write(A_CMP_LO, 32'd5);
        step(1);
        checks++; if (t_intr !== 1'b1) begin failures++; $display("FAIL tmr_rearm got=%b exp=1", t_intr); end
        bus_write(A_CTRL, 32'h1);
        step(1);
        checks++; if (t_intr !== 1'b0) begin failures++; $display("FAIL tmr_clear_tie got=%b exp=0", t_intr); end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        bus_write(A_CTRL, 32'h1);
        bus_write(A_MTIME_HI, 32'hFFFF_FFFF);
        bus_write(A_MTIME_LO, 32'hFFFF_FFFF);
        bus_read(A_MTIME_HI, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre_hi got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_pre_lo got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        step(1);
        bus_read(A_MTIME_HI, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wrap_hi got=%h exp=0", rd); end
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL wrap_lo got=%h exp=0", rd); end
        bus_write(A_MTIME_LO, 32'hFFFF_FFFF);
        step(1);
        bus_read(A_MTIME_HI, rd);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL carry_hi got=%h exp=1", rd); end
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL carry_lo got=%h exp=0", rd); end
        bus_write(A_MTIME_LO, 32'd5);
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'd5) begin failures++; $display("FAIL wprio_lo got=%0d exp=5", rd); end
        bus_write(A_MTIME_HI, 32'h0000_00AB);
        bus_read(A_MTIME_HI, rd);
        checks++; if (rd !== 32'h0000_00AB) begin failures++; $display("FAIL wprio_hi got=%h exp=ab", rd); end
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'd5) begin failures++; $display("FAIL wprio_lo_hold got=%0d exp=5", rd); end
        step(1);
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'd6) begin failures++; $display("FAIL wprio_resume got=%0d exp=6", rd); end
        bus_write(A_CTRL, 32'h0);
    endtask

    task automatic test_ext_irq();
        logic [31:0] rd;
        bus_write(A_CTRL, 32'h4);
        ext_irq_i = 1'b1;
        step(2);
        checks++; if (e_intr !== 1'b0) begin failures++; $display("FAIL ext_early got=%b exp=0", e_intr); end
        step(1);
        checks++; if (e_intr !== 1'b1) begin failures++; $display("FAIL ext_rise got=%b exp=1", e_intr); end
        ext_irq_i = 1'b0;
        step(3);
        checks++; if (e_intr !== 1'b1) begin failures++; $display("FAIL ext_hold got=%b exp=1", e_intr); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ext_pend_set got=%h exp=1", rd); end
        bus_write(A_PEND, 32'h1);
        checks++; if (e_intr !== 1'b0) begin failures++; $display("FAIL ext_w1c_eintr got=%b exp=0", e_intr); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL ext_w1c_pend got=%h exp=0", rd); end
        // Pending latches with EIE=0 and is reported once EIE is set.
        bus_write(A_CTRL, 32'h0);
        ext_irq_i = 1'b1;
        step(3);
        ext_irq_i = 1'b0;
        step(3);
        checks++; if (e_intr !== 1'b0) begin failures++; $display("FAIL ext_masked got=%b exp=0", e_intr); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ext_masked_pend got=%h exp=1", rd); end
        bus_write(A_CTRL, 32'h4);
        step(1);
        checks++; if (e_intr !== 1'b1) begin failures++; $display("FAIL ext_unmask got=%b exp=1", e_intr); end
        // W1C landing on the same cycle as a detected edge: set wins.
        ext_irq_i = 1'b1;
        step(2);
        bus_write(A_PEND, 32'h1);
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h1) begin failures++; $display("FAIL ext_set_wins got=%h exp=1", rd); end
        checks++; if (e_intr !== 1'b1) begin failures++; $display("FAIL ext_set_wins_eintr got=%b exp=1", e_intr); end
        ext_irq_i = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        bus_write(A_CMP_HI, 32'h0);
        bus_write(A_CMP_LO, 32'h0);
        bus_write(A_CTRL, 32'h6);
        step(1);
        checks++; if (t_intr !== 1'b1) begin failures++; $display("FAIL rmid_pre_t got=%b exp=1", t_intr); end
        checks++; if (e_intr !== 1'b1) begin failures++; $display("FAIL rmid_pre_e got=%b exp=1", e_intr); end
        bus_if.sel_i   = 1'b1;
        bus_if.we_i    = 1'b1;
        bus_if.addr_i  = A_MTIME_LO;
        bus_if.wdata_i = 32'd7;
        rst_ni         = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni       = 1'b1;
        bus_if.sel_i = 1'b0;
        bus_if.we_i  = 1'b0;
        bus_read(A_MTIME_LO, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_mtime_lo got=%h exp=0", rd); end
        bus_read(A_MTIME_HI, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_mtime_hi got=%h exp=0", rd); end
        bus_read(A_CMP_LO, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rmid_cmp_lo got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        bus_read(A_CMP_HI, rd);
        checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rmid_cmp_hi got=%h exp=%h", rd, 32'hFFFF_FFFF); end
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_ctrl got=%h exp=0", rd); end
        bus_read(A_PEND, rd);
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rmid_pend got=%h exp=0", rd); end
        checks++; if (t_intr !== 1'b0) begin failures++; $display("FAIL rmid_t_intr got=%b exp=0", t_intr); end
        checks++; if (e_intr !== 1'b0) begin failures++; $display("FAIL rmid_e_intr got=%b exp=0", e_intr); end
    endtask

    initial begin
        bus_if.sel_i   = 1'b0;
        bus_if.we_i    = 1'b0;
        bus_if.addr_i  = '0;
        bus_if.wdata_i = '0;
        test_reset();
        test_decode();
        test_prescaler();
        test_timer_irq();
        test_wrap();
        test_ext_irq();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
